// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential PCs to a 1-cycle synchronous
// instruction memory and buffers returned words for decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic [31:0]   pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    fetch_t        fifo_q [FIFO_DEPTH];

    logic          pop;
    logic          push;
    logic [CW:0]   occ;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign if_valid = (count != '0);
    assign pop      = if_valid && id_ready;
    assign push     = inflight && !redirect_valid;

    // Occupancy after this edge if nothing new were issued; the word
    // already in flight has a slot reserved for it.
    assign occ = {1'b0, count} + {{CW{1'b0}}, inflight}
               - {{CW{1'b0}}, pop};

    assign imem_req  = rst_n && !redirect_valid
                     && (occ < (CW + 1)'(FIFO_DEPTH));
    assign imem_addr = pc;
    assign if_pc     = fifo_q[head].pc;
    assign if_instr  = fifo_q[head].instr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc & 32'hFFFF_FFFC;
            inflight <= 1'b0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= pc;
                pc          <= pc + 32'd4;
            end
            if (push) tail <= next_ptr(tail);
            if (pop)  head <= next_ptr(head);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Payload is left unreset; if_valid qualifies it.
    always_ff @(posedge clk) begin
        if (rst_n && push)
            fifo_q[tail] <= '{pc: inflight_pc, instr: imem_rdata};
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected {pc,instr} pairs are
// queued per path and matched against every decode handshake.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;

    logic [31:0] w_imem_addr;
    logic        w_imem_req;
    logic [31:0] w_imem_rdata;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic        w_if_valid;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_instr;
    logic        w_id_ready;

    logic [31:0] mem [0:1023];
    logic [63:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_del    = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .id_ready      (id_ready)
    );

    instr_fetch_unit #(
        .RESET_PC  (32'hFFFF_FFF8),
        .FIFO_DEPTH(2)
    ) dut_wrap (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (w_imem_addr),
        .imem_req      (w_imem_req),
        .imem_rdata    (w_imem_rdata),
        .redirect_valid(w_redirect_valid),
        .redirect_pc   (w_redirect_pc),
        .if_valid      (w_if_valid),
        .if_pc         (w_if_pc),
        .if_instr      (w_if_instr),
        .id_ready      (w_id_ready)
    );

    always @(posedge clk) begin
        imem_rdata   <= mem[imem_addr[11:2]];
        w_imem_rdata <= mem[w_imem_addr[11:2]];
    end

    // Scoreboard: every accepted instruction must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && if_valid && id_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL deliver: got pc=%h instr=%h, want none",
                         if_pc, if_instr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({if_pc, if_instr} !== e) begin
                    n_fail++;
                    $display("FAIL deliver: got pc=%h instr=%h, want pc=%h instr=%h",
                             if_pc, if_instr, e[63:32], e[31:0]);
                end
                n_del++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && dut.count > 2) begin
            n_fail++;
            $display("FAIL fifo_count: got %0d, want <= 2", dut.count);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic push_path(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] p;
            p = start + 32'(4 * i);
            exp_q.push_back({p, 32'h1000_0000 + {22'b0, p[11:2]}});
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        id_ready = 1'b0;
        step();
        step();
        n_checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got valid=%b req=%b, want 0 0",
                     if_valid, imem_req);
        end
        n_checks++;
        if (imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h, want 00000000", imem_addr);
        end
        n_checks++;
        if (w_imem_addr !== 32'hFFFF_FFF8 || w_if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wrap: got addr=%h valid=%b, want fffffff8 0",
                     w_imem_addr, w_if_valid);
        end
    endtask

    task automatic test_stream;
        int d0;
        exp_q.delete();
        push_path(32'h0, 40);
        id_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL first_req: got req=%b addr=%h, want 1 00000000",
                     imem_req, imem_addr);
        end
        step();
        n_checks++;
        if (if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: got valid=%b, want 0", if_valid);
        end
        step();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL latency: got valid=%b pc=%h, want 1 00000000",
                     if_valid, if_pc);
        end
        d0 = n_del;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (if_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_gap: cycle %0d got valid=%b, want 1",
                         i, if_valid);
            end
            step();
        end
        n_checks++;
        if (n_del - d0 != 16) begin
            n_fail++;
            $display("FAIL stream_count: got %0d, want 16", n_del - d0);
        end
    endtask

    task automatic test_stall;
        bit found;
        int d0;
        rst_n = 1'b0;
        id_ready = 1'b0;
        step();
        exp_q.delete();
        push_path(32'h0, 40);
        rst_n = 1'b1;
        id_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (if_valid && if_pc == 32'h8) found = 1'b1;
            else step();
        end
        id_ready = 1'b0;
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL stall_reach: got no pc 8, want pc 00000008");
        end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'h8
                || if_instr !== 32'h1000_0002) begin
                n_fail++;
                $display("FAIL stall_head: got v=%b pc=%h i=%h, want 1 8 10000002",
                         if_valid, if_pc, if_instr);
            end
            if (k >= 1) begin
                n_checks++;
                if (imem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_req: got %b, want 0", imem_req);
                end
            end
            step();
        end
        id_ready = 1'b1;
        d0 = n_del;
        step();
        step();
        step();
        n_checks++;
        if (n_del - d0 != 3) begin
            n_fail++;
            $display("FAIL stall_resume: got %0d, want 3", n_del - d0);
        end
    endtask

    task automatic test_redirect_full;
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0102;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_req: got %b, want 0", imem_req);
        end
        step();
        exp_q.delete();
        push_path(32'h100, 20);
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        #1;
        n_checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1
            || imem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL redir_flush: got v=%b req=%b addr=%h, want 0 1 00000100",
                     if_valid, imem_req, imem_addr);
        end
        step();
        n_checks++;
        if (if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_lat: got valid=%b, want 0", if_valid);
        end
        step();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h100
            || if_instr !== 32'h1000_0040) begin
            n_fail++;
            $display("FAIL redir_first: got v=%b pc=%h i=%h, want 1 100 10000040",
                     if_valid, if_pc, if_instr);
        end
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_redirect_pop_double;
        int d0;
        n_checks++;
        if (if_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rp_pre: got valid=%b, want 1", if_valid);
        end
        d0 = n_del;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        n_checks++;
        if (n_del - d0 != 1) begin
            n_fail++;
            $display("FAIL rp_pop: got %0d, want 1", n_del - d0);
        end
        redirect_pc = 32'h80;
        step();
        exp_q.delete();
        push_path(32'h80, 20);
        redirect_valid = 1'b0;
        step();
        n_checks++;
        if (if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rp_lat: got valid=%b, want 0", if_valid);
        end
        step();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h80
            || if_instr !== 32'h1000_0020) begin
            n_fail++;
            $display("FAIL rp_first: got v=%b pc=%h i=%h, want 1 80 10000020",
                     if_valid, if_pc, if_instr);
        end
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_reset_mid;
        n_checks++;
        if (imem_req !== 1'b1 || if_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_pre: got req=%b valid=%b, want 1 1",
                     imem_req, if_valid);
        end
        rst_n = 1'b0;
        id_ready = 1'b0;
        step();
        n_checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b0
            || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rm_reset: got v=%b req=%b addr=%h, want 0 0 0",
                     if_valid, imem_req, imem_addr);
        end
        exp_q.delete();
        push_path(32'h0, 20);
        rst_n = 1'b1;
        id_ready = 1'b1;
        step();
        n_checks++;
        if (if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_stale: got valid=%b pc=%h, want 0",
                     if_valid, if_pc);
        end
        step();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0
            || if_instr !== 32'h1000_0000) begin
            n_fail++;
            $display("FAIL rm_first: got v=%b pc=%h i=%h, want 1 0 10000000",
                     if_valid, if_pc, if_instr);
        end
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_wrap;
        logic [63:0] wq [$];
        logic [63:0] e;
        id_ready = 1'b0;
        rst_n = 1'b0;
        step();
        n_checks++;
        if (w_imem_addr !== 32'hFFFF_FFF8 || w_if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_reset: got addr=%h v=%b, want fffffff8 0",
                     w_imem_addr, w_if_valid);
        end
        wq.push_back({32'hFFFF_FFF8, 32'h1000_03FE});
        wq.push_back({32'hFFFF_FFFC, 32'h1000_03FF});
        wq.push_back({32'h0000_0000, 32'h1000_0000});
        rst_n = 1'b1;
        step();
        step();
        while (wq.size() != 0) begin
            e = wq.pop_front();
            n_checks++;
            if (w_if_valid !== 1'b1 || {w_if_pc, w_if_instr} !== e) begin
                n_fail++;
                $display("FAIL wrap: got v=%b pc=%h i=%h, want pc=%h i=%h",
                         w_if_valid, w_if_pc, w_if_instr, e[63:32], e[31:0]);
            end
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++)
            mem[i] = 32'h1000_0000 + 32'(i);
        rst_n = 1'b0;
        id_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        w_id_ready = 1'b1;
        w_redirect_valid = 1'b0;
        w_redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_redirect_pop_double();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
